// File: rtl/rv32i_multicycle_core.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB over one shared ready/valid memory port.
// Illegal encodings, misaligned targets/addresses and ECALL/EBREAK park the core in HALT.
module rv32i_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] pc_out,
    output logic [31:0] retired
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                           OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0] res_q, res_d, npc_q, npc_d, retired_q, retired_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, halted_q, halted_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    assign opc = instr_q[6:0];
    assign rd  = instr_q[11:7];
    assign f3  = instr_q[14:12];
    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign f7  = instr_q[31:25];

    function automatic logic bad_reg(input logic [4:0] r);
        return {27'b0, r} >= 32'(NUM_REGS);
    endfunction

    logic illegal, is_sys, use_rd, use_rs1, use_rs2;
    logic [31:0] imm;
    always_comb begin
        illegal = 1'b0;
        is_sys  = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL: use_rd = 1'b1;
            OP_JALR: begin use_rd = 1'b1; use_rs1 = 1'b1; illegal = (f3 != 3'd0); end
            OP_BR:   begin use_rs1 = 1'b1; use_rs2 = 1'b1; illegal = (f3 == 3'd2) || (f3 == 3'd3); end
            OP_LD:   begin use_rd = 1'b1; use_rs1 = 1'b1; illegal = (f3 != 3'd2); end
            OP_ST:   begin use_rs1 = 1'b1; use_rs2 = 1'b1; illegal = (f3 != 3'd2); end
            OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                illegal = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                          ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            OP_REG: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                illegal = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OP_FENCE: illegal = (f3 != 3'd0);
            OP_SYS: begin
                is_sys  = (instr_q == 32'h0000_0073) || (instr_q == 32'h0010_0073);
                illegal = !is_sys;
            end
            default: illegal = 1'b1;
        endcase
        if ((use_rd && bad_reg(rd)) || (use_rs1 && bad_reg(rs1)) || (use_rs2 && bad_reg(rs2)))
            illegal = 1'b1;
        case (opc)
            OP_ST:           imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            OP_BR:           imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm = {instr_q[31:12], 12'b0};
            OP_JAL:          imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
            default:         imm = {{20{instr_q[31]}}, instr_q[31:20]};
        endcase
    end

    // Execute datapath works on operands latched in DECODE.
    logic [31:0] op_b, alu, pc_plus4, br_tgt, jalr_tgt, ea, tgt;
    logic        taken, is_jump, is_ldst, misalign, wr_rd;
    always_comb begin
        op_b     = (opc == OP_REG) ? b_q : imm_q;
        pc_plus4 = pc_q + 32'd4;
        br_tgt   = pc_q + imm_q;
        ea       = a_q + imm_q;
        jalr_tgt = ea & ~32'd1;
        case (f3)
            3'd0:    alu = ((opc == OP_REG) && f7[5]) ? a_q - op_b : a_q + op_b;
            3'd1:    alu = a_q << op_b[4:0];
            3'd2:    alu = {31'b0, $signed(a_q) < $signed(op_b)};
            3'd3:    alu = {31'b0, a_q < op_b};
            3'd4:    alu = a_q ^ op_b;
            3'd5:    alu = f7[5] ? 32'($signed(a_q) >>> op_b[4:0]) : a_q >> op_b[4:0];
            3'd6:    alu = a_q | op_b;
            default: alu = a_q & op_b;
        endcase
        case (f3)
            3'd0:    taken = (a_q == b_q);
            3'd1:    taken = (a_q != b_q);
            3'd4:    taken = $signed(a_q) < $signed(b_q);
            3'd5:    taken = !($signed(a_q) < $signed(b_q));
            3'd6:    taken = a_q < b_q;
            3'd7:    taken = !(a_q < b_q);
            default: taken = 1'b0;
        endcase
        tgt      = (opc == OP_JALR) ? jalr_tgt : br_tgt;
        is_jump  = (opc == OP_JAL) || (opc == OP_JALR) || ((opc == OP_BR) && taken);
        is_ldst  = (opc == OP_LD) || (opc == OP_ST);
        misalign = (is_jump && (tgt[1:0] != 2'b00)) || (is_ldst && (ea[1:0] != 2'b00));
        wr_rd    = (opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_JAL) || (opc == OP_JALR) ||
                   (opc == OP_IMM) || (opc == OP_REG) || (opc == OP_LD);
    end

    always_comb begin
        state_d = state_q;     pc_d = pc_q;               instr_d = instr_q;
        a_d = a_q;             b_d = b_q;                 imm_d = imm_q;
        res_d = res_q;         npc_d = npc_q;             retired_d = retired_q;
        mem_req_d = mem_req_q; mem_we_d = mem_we_q;       mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q; halted_d = halted_q;   cause_d = cause_q;
        regs_d = regs_q;
        case (state_q)
            FETCH: begin
                // The first cycle after reset only raises the request.
                if (mem_req_q && mem_ready) begin
                    instr_d   = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = DECODE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end
            end
            DECODE: begin
                a_d   = regs_q[rs1[AW-1:0]];
                b_d   = regs_q[rs2[AW-1:0]];
                imm_d = imm;
                if (illegal) begin
                    state_d = HALT; halted_d = 1'b1; cause_d = 2'd1;
                end else if (is_sys) begin
                    state_d = HALT; halted_d = 1'b1; cause_d = 2'd0;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (misalign) begin
                    state_d = HALT; halted_d = 1'b1; cause_d = 2'd2;
                end else begin
                    npc_d   = pc_plus4;
                    res_d   = alu;
                    state_d = WB;
                    case (opc)
                        OP_LUI:   res_d = imm_q;
                        OP_AUIPC: res_d = br_tgt;
                        OP_JAL, OP_JALR: begin res_d = pc_plus4; npc_d = tgt; end
                        OP_BR:    if (taken) npc_d = br_tgt;
                        OP_LD, OP_ST: begin
                            mem_req_d  = 1'b1;
                            mem_we_d   = (opc == OP_ST);
                            mem_addr_d = ea;
                            if (opc == OP_ST) mem_wdata_d = b_q;
                            state_d    = MEM;
                        end
                        default: ;
                    endcase
                end
            end
            MEM: begin
                if (mem_req_q && mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (opc == OP_LD) res_d = mem_rdata;
                    state_d   = WB;
                end
            end
            WB: begin
                if (wr_rd && (rd != 5'd0)) regs_d[rd[AW-1:0]] = res_q;
                pc_d       = npc_q;
                retired_d  = retired_q + 32'd1;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = npc_q;
                state_d    = FETCH;
            end
            HALT: begin
                halted_d  = 1'b1;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;  pc_q <= RESET_PC;  instr_q <= '0;
            a_q <= '0;  b_q <= '0;  imm_q <= '0;  res_q <= '0;  npc_q <= '0;
            retired_q <= '0;  mem_req_q <= 1'b0;  mem_we_q <= 1'b0;
            mem_addr_q <= '0;  mem_wdata_q <= '0;  halted_q <= 1'b0;  cause_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;  pc_q <= pc_d;  instr_q <= instr_d;
            a_q <= a_d;  b_q <= b_d;  imm_q <= imm_d;  res_q <= res_d;  npc_q <= npc_d;
            retired_q <= retired_d;  mem_req_q <= mem_req_d;  mem_we_q <= mem_we_d;
            mem_addr_q <= mem_addr_d;  mem_wdata_q <= mem_wdata_d;
            halted_q <= halted_d;  cause_q <= cause_d;
            regs_q <= regs_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign halted     = halted_q;
    assign trap_cause = cause_q;
    assign pc_out     = pc_q;
    assign retired    = retired_q;
endmodule
